// File: rtl/di_initiator.sv
// Initiator end of the DI terminal/register transfer interface: takes one command,
// sequences per-word read/write handshakes with the responder, reports final status.
module di_initiator #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic        di_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_term,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_len,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] status,
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    output logic [15:0] di_reg_datai,
    input  logic        di_read_rdy,
    input  logic [15:0] di_reg_datao,
    input  logic        di_write_rdy,
    input  logic [15:0] di_transfer_status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RREQ,
        S_RWAIT,
        S_RSTROBE,
        S_WWAIT,
        S_WSTROBE,
        S_FINISH
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST        = TO_W'(TIMEOUT - 1);
    localparam logic [15:0]     STATUS_TIMEOUT = 16'hFFFE;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_write;
    logic            r_timeout;
    logic            r_done;
    logic            r_rd_valid;
    logic [15:0]     r_term;
    logic [15:0]     r_rd_data;
    logic [15:0]     r_datai;
    logic [15:0]     r_status;
    logic [31:0]     r_addr;
    logic [31:0]     r_len;
    logic [30:0]     r_words;
    logic [TO_W-1:0] r_to;

    logic            w_accept;
    logic            w_rd_go;
    logic            w_wr_take;
    logic            w_to_hit;
    logic            w_waiting;
    logic            w_last_word;
    logic [30:0]     w_words_init;

    assign w_accept     = (r_state == S_IDLE) && cmd_valid;
    assign w_words_init = cmd_len[31:1] + {30'd0, cmd_len[0]};
    // The read slot must be empty (or draining this cycle) before another word is pulled.
    assign w_rd_go      = di_read_rdy && (!r_rd_valid || rd_ready);
    assign w_wr_take    = (r_state == S_WWAIT) && wr_valid && di_write_rdy;
    assign w_last_word  = (r_words == 31'd1);

    always_comb begin
        w_state_next = r_state;
        w_to_hit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero-length command completes from IDLE without raising a mode.
                if (cmd_valid && (cmd_len != 32'd0))
                    w_state_next = cmd_write ? S_WWAIT : S_RREQ;
            end
            S_RREQ:    w_state_next = S_RWAIT;
            S_RWAIT: begin
                if (w_rd_go) begin
                    w_state_next = S_RSTROBE;
                end else if (r_to == TO_LAST) begin
                    w_state_next = S_FINISH;
                    w_to_hit     = 1'b1;
                end
            end
            S_RSTROBE: w_state_next = w_last_word ? S_FINISH : S_RREQ;
            S_WWAIT: begin
                if (w_wr_take) begin
                    w_state_next = S_WSTROBE;
                end else if (r_to == TO_LAST) begin
                    w_state_next = S_FINISH;
                    w_to_hit     = 1'b1;
                end
            end
            S_WSTROBE: w_state_next = w_last_word ? S_FINISH : S_WWAIT;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_waiting = ((r_state == S_RWAIT) || (r_state == S_WWAIT)) && (w_state_next == r_state);

    always_ff @(posedge di_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_term     <= 16'd0;
            r_rd_data  <= 16'd0;
            r_datai    <= 16'd0;
            r_status   <= 16'd0;
            r_addr     <= 32'd0;
            r_len      <= 32'd0;
            r_words    <= 31'd0;
            r_to       <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            r_to    <= w_waiting ? (r_to + TO_W'(1)) : '0;

            if (w_accept) begin
                r_write   <= cmd_write;
                r_term    <= cmd_term;
                r_addr    <= cmd_addr;
                r_len     <= cmd_len;
                r_words   <= w_words_init;
                r_timeout <= 1'b0;
                if (cmd_len == 32'd0) begin
                    r_status <= 16'd0;
                    r_done   <= 1'b1;
                end
            end

            if (w_to_hit)
                r_timeout <= 1'b1;

            if (r_state == S_RSTROBE) begin
                r_rd_data  <= di_reg_datao;
                r_rd_valid <= 1'b1;
            end else if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end

            if (w_wr_take)
                r_datai <= wr_data;

            if ((r_state == S_RSTROBE) || (r_state == S_WSTROBE))
                r_words <= r_words - 31'd1;

            if (r_state == S_FINISH) begin
                r_status <= r_timeout ? STATUS_TIMEOUT : di_transfer_status;
                r_done   <= 1'b1;
            end
        end
    end

    // cmd_ready is masked by reset so every output reads 0 while reset is held.
    assign cmd_ready     = (r_state == S_IDLE) && !reset;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign status        = r_status;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign wr_ready      = w_wr_take;
    assign di_term_addr  = r_term;
    assign di_reg_addr   = r_addr;
    assign di_len        = r_len;
    assign di_read_mode  = (r_state != S_IDLE) && !r_write;
    assign di_write_mode = (r_state != S_IDLE) && r_write;
    assign di_read_req   = (r_state == S_RREQ);
    assign di_read       = (r_state == S_RSTROBE);
    assign di_write      = (r_state == S_WSTROBE);
    assign di_reg_datai  = r_datai;

endmodule

// File: tb/tb_di_initiator.sv
// Directed bench for di_initiator: a small responder/consumer model plus per-scenario tasks.
module tb_di_initiator;

    logic        di_clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_term;
    logic [31:0] cmd_addr, cmd_len;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic        busy, done;
    logic [15:0] status, di_term_addr;
    logic [31:0] di_reg_addr, di_len;
    logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic [15:0] di_reg_datai;
    logic        di_read_rdy;
    logic [15:0] di_reg_datao;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;

    always #5 di_clk = ~di_clk;

    di_initiator #(.TIMEOUT(16), .TO_W(11)) dut (
        .di_clk(di_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_term(cmd_term), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .status(status),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
        .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
        .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic        clr;
    int          rsp_idx, widx;
    logic [15:0] rsp_tab [4];
    logic [15:0] wtab [4];
    int          n_req, n_rd, n_wr, n_done, n_wrrdy, n_rdv, n_rmode, n_wmode, n_viol;
    logic [15:0] rq [$];
    logic [15:0] wq [$];

    assign di_reg_datao = rsp_tab[rsp_idx];
    assign wr_data      = wtab[widx];

    // Responder/producer: advance to the next word after each consumed strobe/accept.
    always @(posedge di_clk) begin
        if (clr) begin
            rsp_idx <= 0;
            widx    <= 0;
        end else begin
            if (di_read && rsp_idx < 3) rsp_idx <= rsp_idx + 1;
            if (wr_ready && wr_valid && widx < 3) widx <= widx + 1;
        end
    end

    always @(negedge di_clk) begin
        if (clr) begin
            n_req = 0; n_rd = 0; n_wr = 0; n_done = 0; n_wrrdy = 0;
            n_rdv = 0; n_rmode = 0; n_wmode = 0; n_viol = 0;
            rq.delete();
            wq.delete();
        end else begin
            if (di_read_req) n_req++;
            if (di_read) n_rd++;
            if (di_write) begin n_wr++; wq.push_back(di_reg_datai); end
            if (rd_valid && rd_ready) rq.push_back(rd_data);
            if (rd_valid) n_rdv++;
            if (di_read_mode) n_rmode++;
            if (di_write_mode) n_wmode++;
            if (wr_ready) n_wrrdy++;
            if (done) n_done++;
            if ((int'(di_read_req) + int'(di_read) + int'(di_write)) > 1 ||
                ((di_read_req || di_read) && !di_read_mode) ||
                (di_write && !di_write_mode) ||
                (wr_ready && !(wr_valid && di_write_rdy)))
                n_viol++;
        end
    end

    task automatic do_clear();
        @(posedge di_clk); #1 clr = 1'b1;
        @(posedge di_clk); #1 clr = 1'b0;
    endtask

    task automatic send_cmd(input logic w, input logic [15:0] t, input logic [31:0] a,
                            input logic [31:0] l);
        @(posedge di_clk); #1;
        cmd_write = w; cmd_term = t; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(posedge di_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge di_clk);
            cyc = i + 1;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if ({busy, done, cmd_ready, rd_valid, wr_ready, di_read_mode, di_write_mode} !== 7'd0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, cmd_ready, rd_valid, wr_ready, di_read_mode, di_write_mode}); end
        n_cmp++; if ({status, rd_data, di_term_addr, di_reg_datai} !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {status, rd_data, di_term_addr, di_reg_datai}); end
        @(posedge di_clk); #1 reset = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        $display("reset: cmd_ready=%b busy=%b", cmd_ready, busy);
    endtask

    task automatic test_read_basic();
        int cyc; bit ok;
        do_clear();
        rd_ready = 1'b1; di_read_rdy = 1'b1; di_transfer_status = 16'h0000;
        send_cmd(1'b0, 16'd1, 32'd5, 32'd6);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_done: got %b want 1", ok); end
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL rd_latency: got %0d want 11", cyc); end
        n_cmp++; if (status !== 16'h0000) begin n_bad++; $display("FAIL rd_status: got %h want 0000", status); end
        n_cmp++; if ({n_req, n_rd} !== {32'd3, 32'd3}) begin n_bad++; $display("FAIL rd_strobes: got req=%0d rd=%0d want 3/3", n_req, n_rd); end
        n_cmp++; if (rq.size() !== 3) begin n_bad++; $display("FAIL rd_count: got %0d want 3", rq.size()); end
        if (rq.size() == 3) begin
            n_cmp++; if ({rq[0], rq[1], rq[2]} !== 48'h1111_2222_3333) begin n_bad++; $display("FAIL rd_words: got %h %h %h want 1111 2222 3333", rq[0], rq[1], rq[2]); end
        end
        n_cmp++; if ({n_rmode, n_wmode} !== {32'd10, 32'd0}) begin n_bad++; $display("FAIL rd_mode_cycles: got %0d/%0d want 10/0", n_rmode, n_wmode); end
        n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL rd_protocol: got %0d violations want 0", n_viol); end
        $display("read len=6: done after %0d cycles, status %h, %0d words", cyc, status, rq.size());
    endtask

    task automatic test_write_stall();
        int cyc; bit ok;
        do_clear();
        wr_valid = 1'b1; di_write_rdy = 1'b0; di_transfer_status = 16'h0000;
        send_cmd(1'b1, 16'h0042, 32'hDEAD_0010, 32'd4);
        repeat (5) @(negedge di_clk);
        n_cmp++; if (n_wrrdy !== 0) begin n_bad++; $display("FAIL wr_stall_ready: got %0d want 0", n_wrrdy); end
        n_cmp++; if ({busy, cmd_ready, di_write_mode, di_read_mode} !== 4'b1010) begin n_bad++; $display("FAIL wr_stall_ctrl: got %b want 1010", {busy, cmd_ready, di_write_mode, di_read_mode}); end
        n_cmp++; if ({di_term_addr, di_reg_addr, di_len} !== {16'h0042, 32'hDEAD_0010, 32'd4}) begin n_bad++; $display("FAIL wr_latched: got %h %h %h want 0042 dead0010 4", di_term_addr, di_reg_addr, di_len); end
        @(posedge di_clk); #1 di_write_rdy = 1'b1;
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %b want 1", ok); end
        n_cmp++; if ({n_wr, n_wrrdy} !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL wr_strobes: got write=%0d ready=%0d want 2/2", n_wr, n_wrrdy); end
        if (wq.size() == 2) begin
            n_cmp++; if ({wq[0], wq[1]} !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL wr_words: got %h %h want a5a5 5a5a", wq[0], wq[1]); end
        end
        n_cmp++; if (status !== 16'h0000) begin n_bad++; $display("FAIL wr_status: got %h want 0000", status); end
        n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL wr_protocol: got %0d violations want 0", n_viol); end
        $display("write len=4 stalled: done, status %h, %0d words", status, wq.size());
    endtask

    task automatic test_read_backpressure();
        int cyc; bit ok; bit seen;
        do_clear();
        rd_ready = 1'b0; di_read_rdy = 1'b1; di_transfer_status = 16'h0000;
        send_cmd(1'b0, 16'd2, 32'd8, 32'd4);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge di_clk);
            if (rd_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_first_word: got %b want 1", seen); end
        repeat (8) @(negedge di_clk);
        n_cmp++; if ({n_rd, 32'(rd_valid), 32'(rd_data)} !== {32'd1, 32'd1, 32'h1111}) begin n_bad++; $display("FAIL bp_hold: got rd=%0d valid=%b data=%h want 1 1 1111", n_rd, rd_valid, rd_data); end
        @(posedge di_clk); #1 rd_ready = 1'b1;
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", ok); end
        n_cmp++; if (rq.size() !== 2 || n_rd !== 2) begin n_bad++; $display("FAIL bp_count: got %0d words %0d strobes want 2/2", rq.size(), n_rd); end
        if (rq.size() == 2) begin
            n_cmp++; if ({rq[0], rq[1]} !== 32'h1111_2222) begin n_bad++; $display("FAIL bp_words: got %h %h want 1111 2222", rq[0], rq[1]); end
        end
        n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL bp_protocol: got %0d violations want 0", n_viol); end
        $display("read len=4 backpressured: %0d words delivered, status %h", rq.size(), status);
    endtask

    task automatic test_read_timeout();
        int cyc; bit ok;
        do_clear();
        rd_ready = 1'b1; di_read_rdy = 1'b0; di_transfer_status = 16'h0000;
        send_cmd(1'b0, 16'd3, 32'd0, 32'd2);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b want 1", ok); end
        n_cmp++; if (cyc !== 19) begin n_bad++; $display("FAIL to_latency: got %0d want 19", cyc); end
        n_cmp++; if (status !== 16'hFFFE) begin n_bad++; $display("FAIL to_status: got %h want fffe", status); end
        n_cmp++; if ({n_rdv, n_rd, n_req} !== {32'd0, 32'd0, 32'd1}) begin n_bad++; $display("FAIL to_activity: got valid=%0d rd=%0d req=%0d want 0 0 1", n_rdv, n_rd, n_req); end
        $display("read timeout: done after %0d cycles, status %h", cyc, status);
        di_read_rdy = 1'b1;
    endtask

    task automatic test_status_and_len();
        int cyc; bit ok;
        do_clear();
        wr_valid = 1'b1; di_write_rdy = 1'b1; di_transfer_status = 16'hFFFF;
        send_cmd(1'b1, 16'hBEEF, 32'd1, 32'd2);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1 || status !== 16'hFFFF) begin n_bad++; $display("FAIL st_passthru: got done=%b status=%h want 1 ffff", ok, status); end
        n_cmp++; if (n_wr !== 1) begin n_bad++; $display("FAIL st_words: got %0d want 1", n_wr); end
        $display("write unknown term: status %h", status);

        do_clear();
        di_transfer_status = 16'h0000;
        send_cmd(1'b0, 16'd4, 32'd9, 32'd0);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1 || cyc !== 1) begin n_bad++; $display("FAIL len0_latency: got done=%b cyc=%0d want 1 1", ok, cyc); end
        n_cmp++; if (status !== 16'h0000) begin n_bad++; $display("FAIL len0_status: got %h want 0000", status); end
        n_cmp++; if ({n_rmode, n_wmode, n_req, n_rd, n_wr} !== 160'd0) begin n_bad++; $display("FAIL len0_quiet: got mode %0d/%0d strobes %0d/%0d/%0d want 0", n_rmode, n_wmode, n_req, n_rd, n_wr); end
        $display("len=0: done after %0d cycle, status %h", cyc, status);

        do_clear();
        send_cmd(1'b1, 16'd5, 32'd16, 32'd3);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1 || n_wr !== 2) begin n_bad++; $display("FAIL len3_words: got done=%b writes=%0d want 1 2", ok, n_wr); end
        if (wq.size() == 2) begin
            n_cmp++; if ({wq[0], wq[1]} !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL len3_data: got %h %h want a5a5 5a5a", wq[0], wq[1]); end
        end
        n_cmp++; if (n_viol !== 0) begin n_bad++; $display("FAIL st_protocol: got %0d violations want 0", n_viol); end
        $display("write len=3: %0d words, status %h", n_wr, status);
    endtask

    task automatic test_reset_midread();
        int cyc; bit ok; bit seen; int done_before;
        do_clear();
        rd_ready = 1'b1; di_read_rdy = 1'b1; di_transfer_status = 16'h0000;
        send_cmd(1'b0, 16'd6, 32'h1234, 32'd6);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge di_clk);
            if (n_rd >= 1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_word1: got %b want 1", seen); end
        done_before = n_done;
        @(posedge di_clk); #3 reset = 1'b1;
        #1;
        n_cmp++; if ({busy, done, cmd_ready, rd_valid, di_read_mode, di_read_req, di_read, di_write} !== 8'd0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0", {busy, done, cmd_ready, rd_valid, di_read_mode, di_read_req, di_read, di_write}); end
        n_cmp++; if ({rd_data, status, di_term_addr, di_reg_addr, di_len} !== 112'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {rd_data, status, di_term_addr, di_reg_addr, di_len}); end
        repeat (3) @(negedge di_clk);
        #1 reset = 1'b0;
        n_cmp++; if (n_done !== done_before) begin n_bad++; $display("FAIL rst_no_done: got %0d want %0d", n_done, done_before); end
        do_clear();
        send_cmd(1'b0, 16'd7, 32'd2, 32'd1);
        wait_done(cyc, ok);
        @(negedge di_clk);
        n_cmp++; if (ok !== 1'b1 || status !== 16'h0000) begin n_bad++; $display("FAIL rst_fresh: got done=%b status=%h want 1 0000", ok, status); end
        n_cmp++; if (rq.size() !== 1) begin n_bad++; $display("FAIL rst_fresh_count: got %0d want 1", rq.size()); end
        if (rq.size() == 1) begin
            n_cmp++; if (rq[0] !== 16'h1111) begin n_bad++; $display("FAIL rst_fresh_word: got %h want 1111", rq[0]); end
        end
        $display("reset mid-read then fresh read: %0d words, status %h", rq.size(), status);
    endtask

    initial begin
        rsp_tab[0] = 16'h1111; rsp_tab[1] = 16'h2222; rsp_tab[2] = 16'h3333; rsp_tab[3] = 16'h4444;
        wtab[0] = 16'hA5A5; wtab[1] = 16'h5A5A; wtab[2] = 16'h0F0F; wtab[3] = 16'hF0F0;
        clr = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_term = '0; cmd_addr = '0; cmd_len = '0;
        rd_ready = 1'b0; wr_valid = 1'b0;
        di_read_rdy = 1'b0; di_write_rdy = 1'b0; di_transfer_status = '0;
        test_reset();
        test_read_basic();
        test_write_stall();
        test_read_backpressure();
        test_read_timeout();
        test_status_and_len();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
